// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among NREQ requesters.
// It latches the winning byte, holds tx_start, then waits for tx_done or the watchdog.
module uart_tx_arbiter #(
  parameter int NREQ       = 4,
  parameter int DWIDTH     = 8,
  parameter int START_HOLD = 16,
  parameter int TIMEOUT    = 4096
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        done,
  output logic                   tx_start,
  output logic [DWIDTH-1:0]      tx_data,
  input  logic                   tx_done,
  output logic                   busy,
  output logic                   timeout_err
);

  localparam int PW = $clog2(NREQ);
  localparam int HW = (START_HOLD > 1) ? $clog2(START_HOLD) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD - 1);
  localparam logic [TW-1:0] WD_LAST   = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] PTR_RST   = PW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [PW-1:0]       owner_q, owner_d;
  logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
  logic [TW-1:0]       wd_cnt_q, wd_cnt_d;
  logic [DWIDTH-1:0]   tx_data_q, tx_data_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [NREQ-1:0]     done_q, done_d;
  logic                timeout_err_q, timeout_err_d;
  logic                tx_done_q, tx_done_d;

  logic                done_rise;
  logic                found;
  logic [PW-1:0]       winner;
  logic [PW-1:0]       idx;
  logic [DWIDTH-1:0]   req_bytes [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_bytes
    assign req_bytes[i] = req_data[i*DWIDTH +: DWIDTH];
  end

  assign done_rise = tx_done & ~tx_done_q;

  // Scan starts just after the last owner so every requester gets a fair turn.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    owner_d       = owner_q;
    hold_cnt_d    = hold_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    tx_data_d     = tx_data_q;
    gnt_d         = '0;
    done_d        = '0;
    timeout_err_d = 1'b0;
    tx_done_d     = tx_done;

    case (state_q)
      IDLE: begin
        if (found) begin
          owner_d        = winner;
          tx_data_d      = req_bytes[winner];
          gnt_d[winner]  = 1'b1;
          hold_cnt_d     = '0;
          state_d        = START;
        end
      end
      START: begin
        if (hold_cnt_q == HOLD_LAST) begin
          wd_cnt_d = '0;
          state_d  = WAIT;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      WAIT: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        // A completion arriving on the last watchdog cycle still counts as success.
        if (done_rise) begin
          done_d[owner_q] = 1'b1;
          ptr_d           = owner_q;
          state_d         = IDLE;
        end else if (wd_cnt_q == WD_LAST) begin
          timeout_err_d = 1'b1;
          ptr_d         = owner_q;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= PTR_RST;
      owner_q       <= '0;
      hold_cnt_q    <= '0;
      wd_cnt_q      <= '0;
      tx_data_q     <= '0;
      gnt_q         <= '0;
      done_q        <= '0;
      timeout_err_q <= 1'b0;
      tx_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      owner_q       <= owner_d;
      hold_cnt_q    <= hold_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      tx_data_q     <= tx_data_d;
      gnt_q         <= gnt_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      tx_done_q     <= tx_done_d;
    end
  end

  assign gnt         = gnt_q;
  assign done        = done_q;
  assign tx_data     = tx_data_q;
  assign timeout_err = timeout_err_q;
  assign tx_start    = (state_q == START);
  assign busy        = (state_q != IDLE);

endmodule
